// File: rtl/wave_meas.sv
// rtl/wave_meas.sv - rising zero-crossing period and peak measurement on a signed sample stream
// A Schmitt level defines the crossings; each window runs from one crossing sample up to the next.
module wave_meas #(
  parameter int WIDTH = 24,
  parameter int CNT_W = 16,
  parameter int HYST  = 24'h010000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_sample_valid,
  input  logic [WIDTH-1:0] i_sample,
  input  logic             i_clear,
  output logic             o_meas_valid,
  output logic [CNT_W-1:0] o_period,
  output logic [WIDTH-1:0] o_max,
  output logic [WIDTH-1:0] o_min,
  output logic [WIDTH:0]   o_pp,
  output logic             o_timeout
);

  localparam logic signed [WIDTH-1:0] HYST_P  = WIDTH'(HYST);
  localparam logic signed [WIDTH-1:0] HYST_N  = -HYST_P;
  localparam logic [CNT_W-1:0]        CNT_PRE = {{(CNT_W-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {S_SYNC, S_ARMED, S_MEAS} state_t;

  state_t                   state_q, state_d;
  logic                     level_q, level_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic signed [WIDTH-1:0]  max_q, max_d;
  logic signed [WIDTH-1:0]  min_q, min_d;
  logic                     meas_valid_q, meas_valid_d;
  logic                     timeout_q, timeout_d;
  logic [CNT_W-1:0]         period_q, period_d;
  logic [WIDTH-1:0]         res_max_q, res_max_d;
  logic [WIDTH-1:0]         res_min_q, res_min_d;
  logic [WIDTH:0]           pp_q, pp_d;

  logic signed [WIDTH-1:0]  smp;
  logic                     above, below, rise, sat;
  logic [WIDTH:0]           span;

  assign smp   = $signed(i_sample);
  assign above = smp >= HYST_P;
  assign below = smp <= HYST_N;
  assign rise  = i_sample_valid && !level_q && above;
  // The next non-edge sample would bring the count to its all-ones limit.
  assign sat   = count_q == CNT_PRE;
  // One extra bit keeps max - min exact for any signed pair.
  assign span  = {max_q[WIDTH-1], max_q} - {min_q[WIDTH-1], min_q};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (i_clear) begin
      state_d = S_SYNC;
    end else if (i_sample_valid) begin
      case (state_q)
        S_SYNC:  if (below) state_d = S_ARMED;
        S_ARMED: if (rise) state_d = S_MEAS;
        S_MEAS:  if (!rise && sat) state_d = S_SYNC;
        default: state_d = S_SYNC;
      endcase
    end
  end

  always_comb begin
    level_d      = level_q;
    count_d      = count_q;
    max_d        = max_q;
    min_d        = min_q;
    meas_valid_d = 1'b0;
    timeout_d    = 1'b0;
    period_d     = period_q;
    res_max_d    = res_max_q;
    res_min_d    = res_min_q;
    pp_d         = pp_q;
    if (i_clear) begin
      level_d = 1'b0;
      count_d = '0;
      max_d   = '0;
      min_d   = '0;
    end else if (i_sample_valid) begin
      if (above) begin
        level_d = 1'b1;
      end else if (below) begin
        level_d = 1'b0;
      end
      case (state_q)
        S_ARMED: begin
          if (rise) begin
            count_d = {{(CNT_W-1){1'b0}}, 1'b1};
            max_d   = smp;
            min_d   = smp;
          end
        end
        S_MEAS: begin
          if (rise) begin
            meas_valid_d = 1'b1;
            period_d     = count_q;
            res_max_d    = max_q;
            res_min_d    = min_q;
            pp_d         = span;
            count_d      = {{(CNT_W-1){1'b0}}, 1'b1};
            max_d        = smp;
            min_d        = smp;
          end else if (sat) begin
            timeout_d = 1'b1;
            count_d   = count_q + 1'b1;
          end else begin
            count_d = count_q + 1'b1;
            if (smp > max_q) max_d = smp;
            if (smp < min_q) min_d = smp;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      level_q      <= 1'b0;
      count_q      <= '0;
      max_q        <= '0;
      min_q        <= '0;
      meas_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
      period_q     <= '0;
      res_max_q    <= '0;
      res_min_q    <= '0;
      pp_q         <= '0;
    end else begin
      level_q      <= level_d;
      count_q      <= count_d;
      max_q        <= max_d;
      min_q        <= min_d;
      meas_valid_q <= meas_valid_d;
      timeout_q    <= timeout_d;
      period_q     <= period_d;
      res_max_q    <= res_max_d;
      res_min_q    <= res_min_d;
      pp_q         <= pp_d;
    end
  end

  assign o_meas_valid = meas_valid_q;
  assign o_timeout    = timeout_q;
  assign o_period     = period_q;
  assign o_max        = res_max_q;
  assign o_min        = res_min_q;
  assign o_pp         = pp_q;

endmodule

// File: tb/tb_wave_meas.sv
// tb/tb_wave_meas.sv - directed vector bench for wave_meas
// Expected results are hand-derived window boundaries for each stimulus pattern.
module tb_wave_meas;

  localparam logic [23:0] P = 24'h100000;
  localparam logic [23:0] N = 24'hF00000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_valid = 1'b0;
  logic [23:0] sample = '0;
  logic        clr = 1'b0;

  logic        mv, to, mv4, to4;
  logic [15:0] period;
  logic [3:0]  period4;
  logic [23:0] mx, mn, mx4, mn4;
  logic [24:0] pp, pp4;

  always #5 clk = ~clk;

  wave_meas dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_sample_valid(sample_valid), .i_sample(sample),
    .i_clear(clr), .o_meas_valid(mv), .o_period(period), .o_max(mx), .o_min(mn),
    .o_pp(pp), .o_timeout(to)
  );

  wave_meas #(.CNT_W(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_sample_valid(sample_valid), .i_sample(sample),
    .i_clear(clr), .o_meas_valid(mv4), .o_period(period4), .o_max(mx4), .o_min(mn4),
    .o_pp(pp4), .o_timeout(to4)
  );

  logic [90:0] got_main, got4;
  assign got_main = {mv, to, period, mx, mn, pp};
  assign got4     = {mv4, to4, 12'd0, period4, mx4, mn4, pp4};

  typedef struct {
    int          tid;
    logic        v;
    logic [23:0] s;
    logic        c;
    logic        sel4;
    logic [90:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad = 0;

  int          cur_tid = 0;
  logic        cur_sel4 = 1'b0;
  logic [15:0] e_per = '0;
  logic [23:0] e_max = '0;
  logic [23:0] e_min = '0;
  logic [24:0] e_pp = '0;

  function automatic logic [23:0] sq(input int i);
    return ((i % 10) < 5) ? P : N;
  endfunction

  function automatic logic [23:0] tri_s(input int i);
    int t, v;
    t = i % 64;
    if (t <= 16) v = t * 32'h40000;
    else if (t <= 48) v = 32'h400000 - (t - 16) * 32'h40000;
    else v = -32'sh400000 + (t - 48) * 32'h40000;
    v = v + (((i % 2) == 1) ? 32'sh8000 : -32'sh8000);
    return v[23:0];
  endfunction

  task automatic set_res(input logic [15:0] p, input logic [23:0] a, input logic [23:0] b,
                         input logic [24:0] d);
    e_per = p; e_max = a; e_min = b; e_pp = d;
  endtask

  task automatic add(input logic v, input logic [23:0] s, input logic c, input logic emv,
                     input logic eto);
    vec_t r;
    r.tid = cur_tid; r.v = v; r.s = s; r.c = c; r.sel4 = cur_sel4;
    r.exp = {emv, eto, e_per, e_max, e_min, e_pp};
    tbl.push_back(r);
  endtask

  task automatic drive(input logic v, input logic [23:0] s, input logic c);
    @(negedge clk);
    sample_valid = v; sample = s; clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input int tid, input int idx, input logic [90:0] got,
                       input logic [90:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL t%0d v%0d: got=%h exp=%h", tid, idx, got, exp);
    end
  endtask

  initial begin
    // square wave starting high: first window opens at sample 10
    cur_tid = 1;
    for (int i = 0; i < 45; i++) begin
      if (i == 20) set_res(16'd10, P, N, 25'h0200000);
      add(1'b1, sq(i), 1'b0, (i >= 20) && (i % 10 == 0), 1'b0);
    end
    // clear mid-window, then SYNC/ARMED/full period again
    cur_tid = 5;
    add(1'b1, P, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 25; i++) add(1'b1, sq(i), 1'b0, i == 20, 1'b0);
    // one valid in three: period stays 10 samples, pulses 30 clocks apart
    cur_tid = 2;
    add(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 45; i++) begin
      add(1'b1, sq(i), 1'b0, (i >= 20) && (i % 10 == 0), 1'b0);
      add(1'b0, 24'h7FFFFF, 1'b0, 1'b0, 1'b0);
      add(1'b0, 24'h800000, 1'b0, 1'b0, 1'b0);
    end
    // exact hysteresis thresholds and full-scale peak-to-peak
    cur_tid = 7;
    add(1'b0, '0, 1'b1, 1'b0, 1'b0);
    add(1'b1, 24'hFF0000, 1'b0, 1'b0, 1'b0);
    add(1'b1, 24'h00FFFF, 1'b0, 1'b0, 1'b0);
    add(1'b1, 24'h010000, 1'b0, 1'b0, 1'b0);
    add(1'b1, 24'h800000, 1'b0, 1'b0, 1'b0);
    add(1'b1, 24'hFF0001, 1'b0, 1'b0, 1'b0);
    set_res(16'd3, 24'h010000, 24'h800000, 25'h0810000);
    add(1'b1, 24'h7FFFFF, 1'b0, 1'b1, 1'b0);
    add(1'b1, 24'h800000, 1'b0, 1'b0, 1'b0);
    set_res(16'd2, 24'h7FFFFF, 24'h800000, 25'h0FFFFFF);
    add(1'b1, 24'h7FFFFF, 1'b0, 1'b1, 1'b0);
    // noisy triangle, period 64
    cur_tid = 3;
    add(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 201; i++) begin
      if (i == 129) set_res(16'd64, 24'h3F8000, 24'hBF8000, 25'h0800000);
      add(1'b1, tri_s(i), 1'b0, (i == 129) || (i == 193), 1'b0);
    end
    // 4-bit counter: timeout, resync, then edge on a saturating sample wins
    cur_tid = 4;
    cur_sel4 = 1'b1;
    set_res(16'd2, 24'h7FFFFF, 24'h800000, 25'h0FFFFFF);
    add(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 35; i++) begin
      if (i == 20) set_res(16'd10, P, N, 25'h0200000);
      add(1'b1, sq(i), 1'b0, (i == 20) || (i == 30), 1'b0);
    end
    for (int k = 0; k < 15; k++) add(1'b1, 24'h200000, 1'b0, 1'b0, k == 9);
    for (int i = 5; i < 30; i++) add(1'b1, sq(i), 1'b0, i == 20, 1'b0);
    add(1'b0, '0, 1'b1, 1'b0, 1'b0);
    add(1'b1, N, 1'b0, 1'b0, 1'b0);
    add(1'b1, P, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 13; k++) add(1'b1, N, 1'b0, 1'b0, 1'b0);
    set_res(16'd14, P, N, 25'h0200000);
    add(1'b1, P, 1'b0, 1'b1, 1'b0);

    repeat (3) @(negedge clk);
    check(0, 0, got_main, '0);
    check(0, 1, got4, '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check(0, 2, got_main, '0);

    foreach (tbl[k]) begin
      drive(tbl[k].v, tbl[k].s, tbl[k].c);
      check(tbl[k].tid, k, tbl[k].sel4 ? got4 : got_main, tbl[k].exp);
    end

    // async reset in the middle of an open window
    drive(1'b0, '0, 1'b1);
    for (int i = 0; i < 25; i++) drive(1'b1, sq(i), 1'b0);
    check(6, 0, got_main, {2'b00, 16'd10, P, N, 25'h0200000});
    #1;
    rst_n = 1'b0;
    #1;
    check(6, 1, got_main, '0);
    check(6, 2, got4, '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 21; i++) begin
      drive(1'b1, sq(i), 1'b0);
      if (i == 20) check(6, 3 + i, got_main, {2'b10, 16'd10, P, N, 25'h0200000});
      else check(6, 3 + i, got_main, '0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wave_meas.md
Name: wave_meas

Overview:
Measurement block on the consuming side of the waveform generator's signed sample stream. It detects rising zero crossings with hysteresis, counts valid samples per period, and tracks the min/max sample value within each period. At the end of each period it publishes period, peak values and peak-to-peak with a one-cycle valid pulse. The bench uses it to check generator frequency and gain settings, and the DSP chain uses it for on-chip self-test.

Parameters:
WIDTH, 24, sample width; signed two's complement.
CNT_W, 16, width of the period counter in samples.
HYST, 24'h010000, hysteresis threshold magnitude; must be positive and less than 2^(WIDTH-1).

Ports:
i_clk  input  1  clock.
i_rst_n  input  1  asynchronous active-low reset.
i_sample_valid  input  1  sample qualifier; the block ignores i_sample when low.
i_sample  input  WIDTH  signed sample.
i_clear  input  1  synchronous restart of measurement; takes priority over i_sample_valid.
o_meas_valid  output  1  one-cycle pulse; all result outputs update on this cycle.
o_period  output  CNT_W  number of valid samples in the last complete period.
o_max  output  WIDTH  signed maximum within the last period.
o_min  output  WIDTH  signed minimum within the last period.
o_pp  output  WIDTH+1  unsigned o_max - o_min.
o_timeout  output  1  one-cycle pulse when the period counter saturates.

Behaviour:
- Reset (async, i_rst_n=0): all outputs 0; FSM goes to SYNC; level=LOW; count=0; max/min registers=0.
- Schmitt level, updated only on valid samples:
  - LOW->HIGH when i_sample >= +HYST.
  - HIGH->LOW when i_sample <= -HYST.
  - Otherwise level holds.
  - A rising event is a LOW->HIGH change on the current valid sample.
- FSM states:
  - SYNC: wait for a valid sample <= -HYST. This forces level LOW, then go to ARMED. This prevents a false first edge when the wave starts positive.
  - ARMED: on a rising event, open a window: count=1, max=min=sample. Go to MEAS.
  - MEAS, valid sample without rising event: count+=1; max=max(max,sample); min=min(min,sample).
  - MEAS, rising event: latch the finished window to outputs (o_period=count, o_max, o_min, o_pp). Pulse o_meas_valid. Open a new window seeded with the crossing sample (count=1, max=min=sample). Stay in MEAS for back-to-back periods.
  - MEAS, count reaches 2^CNT_W-1 on a non-edge valid sample: pulse o_timeout, leave results unchanged, go to SYNC.
- Window definition: from a crossing sample (inclusive) to the next crossing sample (exclusive).
- Latency: o_meas_valid and o_timeout assert in the cycle after the clock edge that accepts the triggering valid sample (registered outputs). Both pulses last exactly one cycle.
- Result outputs hold their values between pulses.
- Signed compares throughout. o_pp is computed in WIDTH+1 bits, so it never overflows (max 2^WIDTH-1).
- i_clear=1: FSM goes to SYNC; level=LOW; count, max and min cleared. The sample on that cycle is dropped. Result outputs keep their last values. No pulses are generated.
- i_sample_valid gaps: all state holds; period is counted in samples, not clocks.
- Timeout and rising event on the same sample: the rising event wins and the period is published.
- Async reset mid-window: the partial window is discarded; no pulse follows.

Test Plan:
1. Square wave ±0x100000, period 10 samples (5 high, 5 low), valid every cycle, starting high. No pulse in the first period. Then o_meas_valid every 10 samples with o_period=10, o_max=0x100000, o_min=0xF00000, o_pp=0x200000.
2. Same square wave with i_sample_valid high 1 cycle in 3. Result is o_period=10; the pulse spacing is 30 clocks.
3. Triangle wave 0..±0x400000 with period 64, plus ±0x008000 noise near zero. Exactly one pulse per period, o_period=64, no extra events from noise inside the hysteresis band.
4. CNT_W=4; square wave at period 10, then a constant 0x200000 after a crossing. o_timeout pulses once after count reaches 15. Last results are held, and the FSM needs a sample <= -HYST before measuring again.
5. i_clear asserted mid-period, then the square wave resumes. No pulse for the interrupted period. The next o_period=10 appears only after SYNC, ARMED and one full period.
6. i_rst_n pulsed low mid-window. All outputs read 0 immediately (async). Measurement restarts from SYNC.
